alu_issue_ctrl: RTL

//  Initiator side of the ALU interface.
//  - Accepts one operation per valid/ready handshake from the decode stage.
//  - Checks opcode and operands, drives alu_enable/opcode/term1/term2, and waits for done.
//  - Captures result and flags, then issues a one-cycle writeback.
//  - Maintains the architectural flag register. Sits between instruction decode and the register file.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_issue_ctrl_if.sv | 39 +++
 rtl/alu_timeout_cnt.sv | 32 +++
 rtl/alu_issue_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, flag bit positions, error codes and FSM encoding for the ALU issue controller.
package alu_pkg;

  typedef enum int unsigned {
    OP_ADD = 0, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_XOR, OP_NOT,
    OP_CMP, OP_MOV, OP_RSR, OP_RSL, OP_LSR, OP_LSL, OP_TST, OP_INC, OP_DEC
  } alu_op_e;

  localparam int unsigned OP_COUNT = 18;

  typedef enum int {
    FLAG_V = 0, FLAG_C = 1, FLAG_N = 2, FLAG_Z = 3
  } flag_idx_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_DIV0    = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  function automatic logic op_legal(input int unsigned opc);
    return opc < OP_COUNT;
  endfunction

  function automatic logic op_divides(input int unsigned opc);
    return (opc == OP_DIV) || (opc == OP_MOD);
  endfunction

  // Compare/test only update the flag register and never write back.
  function automatic logic op_flags_only(input int unsigned opc);
    return (opc == OP_CMP) || (opc == OP_TST);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Decode request, ALU request/response and writeback signals; master is the issue controller.
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 6,
  parameter int REGW  = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [OPW-1:0]   req_opcode;
  logic [WIDTH-1:0] req_op1;
  logic [WIDTH-1:0] req_op2;
  logic [REGW-1:0]  req_dst;

  logic             alu_enable;
  logic [OPW-1:0]   alu_opcode;
  logic [WIDTH-1:0] alu_term1;
  logic [WIDTH-1:0] alu_term2;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;
  logic             alu_done;

  logic             wb_valid;
  logic [REGW-1:0]  wb_dst;
  logic [WIDTH-1:0] wb_data;

  modport master (
    input  req_valid, req_opcode, req_op1, req_op2, req_dst,
    input  alu_result, alu_flags, alu_done,
    output req_ready, alu_enable, alu_opcode, alu_term1, alu_term2,
    output wb_valid, wb_dst, wb_data
  );

  modport slave (
    output req_valid, req_opcode, req_op1, req_op2, req_dst,
    output alu_result, alu_flags, alu_done,
    input  req_ready, alu_enable, alu_opcode, alu_term1, alu_term2,
    input  wb_valid, wb_dst, wb_data
  );
endinterface

// File: rtl/alu_timeout_cnt.sv
// Counts enabled cycles since the last clear; expire_o flags the TIMEOUT-th enabled cycle.
module alu_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU initiator: accepts one op in IDLE, holds the ALU request until done or timeout,
// then writes back for one cycle (no wb backpressure); illegal/div-by-zero abort before issue.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int OPW     = 6,
  parameter int REGW    = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  alu_issue_ctrl_if.master     bus,
  output logic [3:0]           flags_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [1:0]           err_code_o
);

  state_e           state_q;
  logic [OPW-1:0]   opc_q;
  logic [WIDTH-1:0] term1_q;
  logic [WIDTH-1:0] term2_q;
  logic [REGW-1:0]  dst_q;
  logic             enable_q;
  logic             wb_valid_q;
  logic [WIDTH-1:0] wb_data_q;
  logic [3:0]       flags_q;
  logic             err_q;
  logic [1:0]       err_code_q;

  logic req_illegal;
  logic req_div0;
  logic expire;

  assign req_illegal = !op_legal(32'(bus.req_opcode));
  assign req_div0    = op_divides(32'(bus.req_opcode)) && (bus.req_op2 == '0);

  // Counter is held clear whenever idle, so every issue starts from zero.
  alu_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_q == ST_IDLE),
    .en_i     (state_q == ST_ISSUE),
    .expire_o (expire)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      opc_q      <= '0;
      term1_q    <= '0;
      term2_q    <= '0;
      dst_q      <= '0;
      enable_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      flags_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            opc_q   <= bus.req_opcode;
            term1_q <= bus.req_op1;
            term2_q <= bus.req_op2;
            dst_q   <= bus.req_dst;
            if (req_illegal) begin
              state_q    <= ST_ERR;
              err_q      <= 1'b1;
              err_code_q <= ERR_ILLEGAL;
            end else if (req_div0) begin
              state_q    <= ST_ERR;
              err_q      <= 1'b1;
              err_code_q <= ERR_DIV0;
            end else begin
              state_q  <= ST_ISSUE;
              enable_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          // A done on the final allowed cycle still wins over the timeout.
          if (bus.alu_done) begin
            enable_q  <= 1'b0;
            flags_q   <= bus.alu_flags;
            wb_data_q <= bus.alu_result;
            if (op_flags_only(32'(opc_q))) begin
              state_q <= ST_IDLE;
            end else begin
              state_q    <= ST_WB;
              wb_valid_q <= 1'b1;
            end
          end else if (expire) begin
            enable_q   <= 1'b0;
            state_q    <= ST_ERR;
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
          end
        end
        ST_WB:   state_q <= ST_IDLE;
        ST_ERR:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.alu_enable = enable_q;
  assign bus.alu_opcode = opc_q;
  assign bus.alu_term1  = term1_q;
  assign bus.alu_term2  = term2_q;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_dst     = dst_q;
  assign bus.wb_data    = wb_data_q;
  assign flags_o        = flags_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign err_o          = err_q;
  assign err_code_o     = err_code_q;

endmodule
